// File: rtl/preamble_pkg.sv
// Definitions shared by the preamble stripper and the preamble inserter:
// the preamble word, its length in words, FSM encodings and a saturating counter helper.
package preamble_pkg;

  localparam logic [15:0] C_PREAMBLE_PATTERN = 16'hABCD;
  localparam int unsigned C_PREAMBLE_LEN     = 1;

  localparam logic [1:0] C_HUNT    = 2'd0;
  localparam logic [1:0] C_PAYLOAD = 2'd1;
  localparam logic [1:0] C_DROP    = 2'd2;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry AXI-Stream output register. A new word may be loaded in the
// same cycle the held word drains, so throughput is one word per cycle.
module axis_out_reg #(
  parameter int C_DATA_WIDTH = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    load,
  input  logic [C_DATA_WIDTH-1:0] load_data,
  input  logic                    load_last,
  output logic                    can_load,
  output logic [C_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast
);

  assign can_load = ~m_axis_tvalid | m_axis_tready;

  // NOTE: registers are updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tvalid <= 1'b0;
    end else if (load) begin
      m_axis_tdata  <= load_data;
      m_axis_tlast  <= load_last;
      m_axis_tvalid <= 1'b1;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/preamble_strip.sv
// Removes a one-word preamble from each AXI-Stream frame, forwards at most
// C_FRAME_LEN payload words and counts good and errored frames.
module preamble_strip
  import preamble_pkg::*;
#(
  parameter int C_DATA_WIDTH = 16,
  parameter int C_FRAME_LEN  = 10
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [C_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  output logic [C_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic                    frame_err_o,
  output logic [15:0]             good_cnt_o,
  output logic [15:0]             err_cnt_o
);

  localparam int                    CW       = $clog2(C_FRAME_LEN + 1);
  localparam logic [C_DATA_WIDTH-1:0] PATTERN = C_DATA_WIDTH'(C_PREAMBLE_PATTERN);
  localparam logic [CW-1:0]         LAST_IDX = CW'(C_FRAME_LEN - 1);

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          hs, load, load_last, can_load;
  logic          err_evt, good_evt;

  // Input is refused during reset so an in-flight word is never accepted.
  assign s_axis_tready = ~rst_i & ((state == C_PAYLOAD) ? can_load : 1'b1);
  assign hs            = s_axis_tvalid & s_axis_tready;

  // NOTE: every output of this block gets a default first so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load      = 1'b0;
    load_last = s_axis_tlast;
    err_evt   = 1'b0;
    good_evt  = 1'b0;
    case (state)
      C_HUNT: begin
        if (hs) begin
          if (s_axis_tdata == PATTERN && !s_axis_tlast) begin
            state_nxt = C_PAYLOAD;
            cnt_nxt   = '0;
          end else begin
            err_evt   = 1'b1;
            state_nxt = s_axis_tlast ? C_HUNT : C_DROP;
          end
        end
      end
      C_PAYLOAD: begin
        if (hs) begin
          load = 1'b1;
          if (s_axis_tlast) begin
            good_evt  = 1'b1;
            state_nxt = C_HUNT;
          end else if (cnt == LAST_IDX) begin
            // Oversized frame: close it downstream, discard the remainder.
            load_last = 1'b1;
            err_evt   = 1'b1;
            state_nxt = C_DROP;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      C_DROP: begin
        if (hs && s_axis_tlast) state_nxt = C_HUNT;
      end
      default: state_nxt = C_HUNT;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= C_HUNT;
      cnt         <= '0;
      frame_err_o <= 1'b0;
      good_cnt_o  <= '0;
      err_cnt_o   <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      frame_err_o <= err_evt;
      if (good_evt) good_cnt_o <= sat_inc16(good_cnt_o);
      if (err_evt)  err_cnt_o  <= sat_inc16(err_cnt_o);
    end
  end

  axis_out_reg #(
    .C_DATA_WIDTH (C_DATA_WIDTH)
  ) u_out_reg (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .load          (load),
    .load_data     (s_axis_tdata),
    .load_last     (load_last),
    .can_load      (can_load),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast)
  );

endmodule

// File: tb/tb_preamble_strip.sv
// Bench for preamble_strip: directed frame scenarios followed by random frames
// with random back-pressure, checked against a frame-level reference model.
module tb_preamble_strip;
  import preamble_pkg::*;

  localparam int W  = 16;
  localparam int FL = 10;

  typedef logic [16:0] beat_t;   // {tlast, tdata}

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [W-1:0]  s_tdata;
  logic          s_tvalid, s_tready, s_tlast;
  logic [W-1:0]  m_tdata;
  logic          m_tvalid, m_tready, m_tlast;
  logic          frame_err;
  logic [15:0]   good_cnt, err_cnt;

  always #5 clk_i = ~clk_i;

  preamble_strip #(
    .C_DATA_WIDTH (W),
    .C_FRAME_LEN  (FL)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tlast  (s_tlast),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast),
    .frame_err_o   (frame_err),
    .good_cnt_o    (good_cnt),
    .err_cnt_o     (err_cnt)
  );

  int    n_pass = 0;
  int    n_total = 0;
  beat_t cur[$];
  beat_t out_q[$];
  beat_t exp_q[$];
  int    out_cyc_q[$];
  int    acc_q[$];
  int    cyc = 0;
  int    err_pulses = 0;
  int    exp_good = 0;
  int    exp_err = 0;
  int    stall_viol = 0;
  logic  prev_stall = 1'b0;
  beat_t prev_beat;
  bit    rand_bp = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Output monitor: records handshakes, error pulses and stall stability.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (m_tvalid && m_tready) begin
        out_q.push_back({m_tlast, m_tdata});
        out_cyc_q.push_back(cyc);
      end
      if (frame_err) err_pulses++;
      if (prev_stall && (!m_tvalid || {m_tlast, m_tdata} != prev_beat)) stall_viol++;
      prev_stall = m_tvalid && !m_tready;
      prev_beat  = {m_tlast, m_tdata};
    end else begin
      prev_stall = 1'b0;
    end
  end

  always @(posedge clk_i) begin
    if (rand_bp) begin
      #1;
      m_tready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic send_word(input logic [15:0] d, input logic l);
    int n = 0;
    s_tdata  = d;
    s_tlast  = l;
    s_tvalid = 1'b1;
    forever begin
      @(negedge clk_i);
      if (s_tready) break;
      n++;
      if (n > 500) begin
        $display("FAIL send_word: s_axis_tready stuck low, observed=0 expected=1");
        $display("%0d/%0d checks passed", n_pass, n_total + 1);
        $fatal(1, "input handshake timeout");
      end
    end
    acc_q.push_back(cyc);
    @(posedge clk_i);
    #1;
    s_tvalid = 1'b0;
  endtask

  // Frame-level reference: a frame is good only if it starts with the
  // preamble and carries 1..FL payload words; longer frames are truncated.
  task automatic model_frame();
    int n;
    if (cur.size() < 2 || cur[0][15:0] != C_PREAMBLE_PATTERN) begin
      exp_err++;
      return;
    end
    n = cur.size() - 1;
    if (n <= FL) begin
      for (int i = 1; i <= n; i++) exp_q.push_back({i == n, cur[i][15:0]});
      exp_good++;
    end else begin
      for (int i = 1; i <= FL; i++) exp_q.push_back({i == FL, cur[i][15:0]});
      exp_err++;
    end
  endtask

  task automatic send_frame();
    foreach (cur[i]) send_word(cur[i][15:0], cur[i][16]);
    model_frame();
  endtask

  task automatic build_good(input int n, input logic [15:0] base);
    cur.delete();
    cur.push_back({1'b0, C_PREAMBLE_PATTERN});
    for (int i = 1; i <= n; i++) cur.push_back({i == n, base + 16'(i)});
  endtask

  task automatic compare_outputs(input string tag);
    int n = 0;
    repeat (2) begin @(posedge clk_i); #1; end
    while (m_tvalid && n < 500) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    chk({tag, "_drained"}, 32'(m_tvalid), 32'd0);
    chk({tag, "_count"}, 32'(out_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_word%0d", tag, i), 32'(out_q[i]), 32'(exp_q[i]));
    chk({tag, "_good_cnt"}, 32'(good_cnt), 32'(exp_good));
    chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(exp_err));
    chk({tag, "_err_pulses"}, 32'(err_pulses), 32'(exp_err));
    out_q.delete();
    exp_q.delete();
    out_cyc_q.delete();
    acc_q.delete();
  endtask

  initial begin
    rst_i    = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_s_tready", 32'(s_tready), 32'd0);
    chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_m_tdata", 32'(m_tdata), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_good_cnt", 32'(good_cnt), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // Basic frame: one cycle latency, one word per cycle
    build_good(3, 16'h0000);
    send_frame();
    repeat (3) begin @(posedge clk_i); #1; end
    chk("basic_outs", 32'(out_cyc_q.size()), 32'd3);
    for (int i = 0; i < 3 && i < out_cyc_q.size() && i + 1 < acc_q.size(); i++)
      chk($sformatf("basic_latency%0d", i), 32'(out_cyc_q[i] - acc_q[i + 1]), 32'd1);
    if (out_cyc_q.size() == 3)
      chk("basic_throughput", 32'(out_cyc_q[2] - out_cyc_q[0]), 32'd2);
    compare_outputs("basic");

    // Three-cycle downstream stall in mid-frame
    build_good(3, 16'h0000);
    send_word(cur[0][15:0], 1'b0);
    send_word(cur[1][15:0], 1'b0);
    m_tready = 1'b0;
    fork
      send_word(cur[2][15:0], 1'b0);
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk_i);
          chk($sformatf("stall_valid%0d", i), 32'(m_tvalid), 32'd1);
          chk($sformatf("stall_data%0d", i), 32'(m_tdata), 32'h0001);
          chk($sformatf("stall_s_tready%0d", i), 32'(s_tready), 32'd0);
          @(posedge clk_i);
        end
        #1;
        m_tready = 1'b1;
      end
    join
    send_word(cur[3][15:0], 1'b1);
    model_frame();
    compare_outputs("stall");

    // Bad preamble frame followed by a valid one
    cur.delete();
    cur.push_back({1'b0, 16'h1234});
    cur.push_back({1'b1, 16'h0005});
    send_frame();
    cur.delete();
    cur.push_back({1'b0, C_PREAMBLE_PATTERN});
    cur.push_back({1'b1, 16'h00AA});
    send_frame();
    compare_outputs("badpre");

    // Oversized frame: 12 payload words, then a normal frame
    build_good(12, 16'h0100);
    send_frame();
    build_good(1, 16'h0054);
    send_frame();
    compare_outputs("overlong");

    // Empty frame, then two back-to-back good frames
    cur.delete();
    cur.push_back({1'b1, C_PREAMBLE_PATTERN});
    send_frame();
    build_good(1, 16'h0000);
    send_frame();
    build_good(1, 16'h0001);
    send_frame();
    compare_outputs("empty_b2b");

    // Asynchronous reset mid-frame
    send_word(C_PREAMBLE_PATTERN, 1'b0);
    send_word(16'h0021, 1'b0);
    send_word(16'h0022, 1'b0);
    chk("arst_pre_valid", 32'(m_tvalid), 32'd1);
    #2;
    rst_i = 1'b1;
    #1;
    chk("arst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("arst_m_tdata", 32'(m_tdata), 32'd0);
    chk("arst_m_tlast", 32'(m_tlast), 32'd0);
    chk("arst_s_tready", 32'(s_tready), 32'd0);
    chk("arst_good_cnt", 32'(good_cnt), 32'd0);
    chk("arst_err_cnt", 32'(err_cnt), 32'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    exp_good   = 0;
    exp_err    = 0;
    err_pulses = 0;
    out_q.delete();
    exp_q.delete();
    out_cyc_q.delete();
    acc_q.delete();
    build_good(1, 16'h0006);
    send_frame();
    compare_outputs("after_rst");

    // Random frames with random back-pressure
    rand_bp = 1'b1;
    for (int f = 0; f < 40; f++) begin
      int kind;
      int n;
      logic [15:0] d;
      kind = $urandom_range(0, 4);
      cur.delete();
      case (kind)
        0, 1: begin
          n = $urandom_range(1, FL);
          cur.push_back({1'b0, C_PREAMBLE_PATTERN});
          for (int i = 0; i < n; i++) cur.push_back({i == n - 1, 16'($urandom)});
        end
        2: begin
          n = $urandom_range(FL + 1, FL + 4);
          cur.push_back({1'b0, C_PREAMBLE_PATTERN});
          for (int i = 0; i < n; i++) cur.push_back({i == n - 1, 16'($urandom)});
        end
        3: begin
          n = $urandom_range(1, 4);
          d = 16'($urandom);
          if (d == C_PREAMBLE_PATTERN) d = 16'h1234;
          cur.push_back({n == 1, d});
          for (int i = 1; i < n; i++) cur.push_back({i == n - 1, 16'($urandom)});
        end
        default: cur.push_back({1'b1, C_PREAMBLE_PATTERN});
      endcase
      send_frame();
      repeat ($urandom_range(0, 2)) begin @(posedge clk_i); #1; end
    end
    rand_bp = 1'b0;
    @(posedge clk_i);
    #2;
    m_tready = 1'b1;
    compare_outputs("random");
    chk("stall_stability", 32'(stall_viol), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
